// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - WM8731 register map, power-on defaults and responder FSM states
package wm8731_pkg;

    localparam logic [6:0] WM8731_ADDR = 7'h1A;

    localparam int R_LVOL   = 2;
    localparam int R_RVOL   = 3;
    localparam int R_ACTIVE = 9;
    localparam int R_RESET  = 15;
    localparam int R_LAST   = 9;

    // Packed so element [i] is register Ri; R10..R15 have no storage meaning and stay 0.
    localparam logic [15:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008, 9'h00A,
        9'h079, 9'h079, 9'h097, 9'h097
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEVADDR,
        S_ACK0,
        S_BYTE1,
        S_ACK1,
        S_BYTE2,
        S_ACK2,
        S_DONE,
        S_IGNORE
    } resp_state_t;

endpackage

// File: rtl/wm8731_i2c_responder_line_sync.sv
// rtl/wm8731_i2c_responder_line_sync.sv - SCL/SDA synchroniser and bus event detector
// I2C_RESP_GLITCH_FILTER_EN adds a 3-sample majority filter on both lines.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i2c,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_q;
    logic                   sda_q;

    // Idle bus is high; resetting to 1 avoids a phantom edge after reset.
    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [2:0] scl_win;
    logic [2:0] sda_win;

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_win <= '1;
            sda_win <= '1;
        end else begin
            scl_win <= {scl_win[1:0], scl_sync[SYNC_STAGES-1]};
            sda_win <= {sda_win[1:0], sda_sync[SYNC_STAGES-1]};
        end
    end

    assign scl_f = (scl_win[0] & scl_win[1]) | (scl_win[0] & scl_win[2]) | (scl_win[1] & scl_win[2]);
    assign sda_f = (sda_win[0] & sda_win[1]) | (sda_win[0] & sda_win[2]) | (sda_win[1] & sda_win[2]);
`else
    assign scl_f = scl_sync[SYNC_STAGES-1];
    assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // START/STOP need SCL high on both samples, so a simultaneous SCL change wins.
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign sda_s     = sda_f;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// rtl/wm8731_i2c_responder.sv - WM8731 control-port I2C write responder with register image
// Build option I2C_RESP_GLITCH_FILTER_EN enables the line glitch filter in i2c_line_sync.
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM8731_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i2c,
    input  logic       reset_n,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       reg_wr_stb,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    output logic [6:0] left_vol,
    output logic [6:0] right_vol,
    output logic       codec_active,
    output logic [7:0] frame_count,
    output logic [3:0] nack_count
);

    resp_state_t state;
    resp_state_t state_n;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        sda_s;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  byte1;
    logic        byte_done;
    logic        in_byte;
    logic        commit;
    logic        nack_inc;
    logic        ack_drive;
    logic [6:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [8:0]  regs [16];

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i2c  (clk_i2c),
        .reset_n  (reset_n),
        .scl      (I2C_SCLK),
        .sda      (I2C_SDAT),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    assign in_byte   = state inside {S_DEVADDR, S_BYTE1, S_BYTE2, S_DONE};
    assign byte_done = in_byte && (bit_cnt == 4'd8) && scl_fall;
    assign ack_drive = state inside {S_ACK0, S_ACK1, S_ACK2};
    assign I2C_SDAT  = ack_drive ? 1'b0 : 1'bz;
    assign wr_addr   = byte1[7:1];
    assign wr_data   = {byte1[0], shreg};

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        commit   = 1'b0;
        nack_inc = 1'b0;
        if (start_det) begin
            state_n = S_DEVADDR;
        end else if (stop_det) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_DEVADDR: if (byte_done) begin
                    if (shreg == {DEV_ADDR, 1'b0}) begin
                        state_n = S_ACK0;
                    end else begin
                        state_n  = S_IGNORE;
                        nack_inc = 1'b1;
                    end
                end
                S_ACK0:  if (scl_fall)  state_n = S_BYTE1;
                S_BYTE1: if (byte_done) state_n = S_ACK1;
                S_ACK1:  if (scl_fall)  state_n = S_BYTE2;
                S_BYTE2: if (byte_done) state_n = S_ACK2;
                S_ACK2: if (scl_fall) begin
                    state_n = S_DONE;
                    commit  = 1'b1;
                end
                S_DONE: if (byte_done) begin
                    state_n  = S_IGNORE;
                    nack_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // shreg keeps byte 2 through ACK2 because shifting only happens in byte states.
    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            byte1       <= '0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            frame_count <= '0;
            nack_count  <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= REG_DEFAULTS[i];
        end else begin
            reg_wr_stb <= commit;
            if (start_det || stop_det || (state_n != state)) begin
                bit_cnt <= '0;
            end else if (scl_rise && in_byte && (bit_cnt != 4'd8)) begin
                shreg   <= {shreg[6:0], sda_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if ((state == S_BYTE1) && byte_done) byte1 <= shreg;
            if (nack_inc && (nack_count != 4'hF)) nack_count <= nack_count + 4'd1;
            if (commit) begin
                reg_wr_addr <= wr_addr;
                reg_wr_data <= wr_data;
                frame_count <= frame_count + 8'd1;
                if (wr_addr == 7'(R_RESET)) begin
                    for (int i = 0; i < 16; i++) regs[i] <= REG_DEFAULTS[i];
                end else if (wr_addr <= 7'(R_LAST)) begin
                    regs[wr_addr[3:0]] <= wr_data;
                end
            end
        end
    end

    assign left_vol     = regs[R_LVOL][6:0];
    assign right_vol    = regs[R_RVOL][6:0];
    assign codec_active = regs[R_ACTIVE][0];

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb/tb_wm8731_i2c_responder.sv - self-checking bench for wm8731_i2c_responder
module tb_wm8731_i2c_responder;

    localparam int Q = 10;

    logic       clk_i2c   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_bus;
    logic       reg_wr_stb;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic [6:0] left_vol;
    logic [6:0] right_vol;
    logic       codec_active;
    logic [7:0] frame_count;
    logic [3:0] nack_count;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    wm8731_i2c_responder dut (
        .clk_i2c     (clk_i2c),
        .reset_n     (reset_n),
        .I2C_SCLK    (scl),
        .I2C_SDAT    (sda_bus),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .left_vol    (left_vol),
        .right_vol   (right_vol),
        .codec_active(codec_active),
        .frame_count (frame_count),
        .nack_count  (nack_count)
    );

    always #5 clk_i2c = ~clk_i2c;

    int stb_cycles = 0;
    always @(posedge clk_i2c) if (reg_wr_stb === 1'b1) stb_cycles++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register image and counters derived from frame contents.
    logic [8:0] m_regs [16];
    int         m_fc;
    int         m_nc;
    logic [6:0] m_wa;
    logic [8:0] m_wd;

    function automatic logic [8:0] spec_default(input int i);
        case (i)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_defaults();
        for (int i = 0; i < 16; i++) m_regs[i] = spec_default(i);
    endtask

    task automatic model_reset();
        model_defaults();
        m_fc = 0;
        m_nc = 0;
        m_wa = '0;
        m_wd = '0;
    endtask

    task automatic model_frame(input logic [3:0][7:0] b, input int n,
                               output logic [3:0] exp_acks, output int exp_stb);
        int         a;
        logic [8:0] d;
        exp_acks = '0;
        exp_stb  = 0;
        if (b[0] != 8'h34) begin
            m_nc = (m_nc < 15) ? m_nc + 1 : 15;
        end else begin
            for (int k = 0; k < n && k < 3; k++) exp_acks[k] = 1'b1;
            if (n >= 3) begin
                a = int'(b[1]) / 2;
                d = {b[1][0], b[2]};
                if (a == 15) model_defaults();
                else if (a < 10) m_regs[a] = d;
                m_fc    = (m_fc + 1) % 256;
                m_wa    = 7'(a);
                m_wd    = d;
                exp_stb = 1;
            end
            if (n >= 4) m_nc = (m_nc < 15) ? m_nc + 1 : 15;
        end
    endtask

    task automatic send_bit(input logic b, input logic spike, output logic s);
        repeat (2) @(negedge clk_i2c);
        m_sda_low = ~b;
        repeat (2) @(negedge clk_i2c);
        if (spike) begin
            scl = 1'b1;
            @(negedge clk_i2c);
            scl = 1'b0;
        end else begin
            @(negedge clk_i2c);
        end
        repeat (Q - 5) @(negedge clk_i2c);
        scl = 1'b1;
        repeat (Q) @(negedge clk_i2c);
        s = sda_bus;
        repeat (Q) @(negedge clk_i2c);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic spike, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], spike && (i == 3), s);
        send_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic i2c_start();
        @(negedge clk_i2c);
        scl       = 1'b1;
        m_sda_low = 1'b0;
        repeat (Q) @(negedge clk_i2c);
        m_sda_low = 1'b1;
        repeat (Q) @(negedge clk_i2c);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        repeat (2) @(negedge clk_i2c);
        m_sda_low = 1'b1;
        repeat (Q) @(negedge clk_i2c);
        scl = 1'b1;
        repeat (Q) @(negedge clk_i2c);
        m_sda_low = 1'b0;
        repeat (Q) @(negedge clk_i2c);
    endtask

    task automatic run_frame(input logic [3:0][7:0] b, input int n, input int spike_byte,
                             output logic [3:0] acks, output int stb_delta);
        logic a;
        int   s0;
        s0   = stb_cycles;
        acks = '0;
        i2c_start();
        for (int k = 0; k < n; k++) begin
            send_byte(b[k], k == spike_byte, a);
            acks[k] = a;
        end
        i2c_stop();
        repeat (10) @(negedge clk_i2c);
        stb_delta = stb_cycles - s0;
    endtask

    task automatic check_model(input string tag, input logic [3:0] acks, input logic [3:0] ea,
                               input int sd, input int es);
        chk({tag, "_acks"}, 32'(acks), 32'(ea));
        chk({tag, "_stb"}, sd, es);
        chk({tag, "_lvol"}, 32'(left_vol), 32'(m_regs[2][6:0]));
        chk({tag, "_rvol"}, 32'(right_vol), 32'(m_regs[3][6:0]));
        chk({tag, "_active"}, 32'(codec_active), 32'(m_regs[9][0]));
        chk({tag, "_fc"}, 32'(frame_count), m_fc);
        chk({tag, "_nc"}, 32'(nack_count), m_nc);
        chk({tag, "_waddr"}, 32'(reg_wr_addr), 32'(m_wa));
        chk({tag, "_wdata"}, 32'(reg_wr_data), 32'(m_wd));
    endtask

    typedef struct {
        int              n;
        logic [3:0][7:0] b;
        logic [3:0]      acks;
        int              stb;
        logic [6:0]      lv;
        logic [6:0]      rv;
        logic            act;
        logic [7:0]      fc;
        logic [3:0]      nc;
        logic [6:0]      wa;
        logic [8:0]      wd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [3:0]      acks;
        logic [3:0]      ea;
        logic [3:0][7:0] b;
        int              sd;
        int              es;
        int              n;
        int              a;
        logic            seen;

        tbl[0] = '{3, {8'h00, 8'h79, 8'h04, 8'h34}, 4'b0111, 1, 7'h79, 7'h79, 1'b0, 8'd1, 4'd0, 7'h02, 9'h079};
        tbl[1] = '{3, {8'h00, 8'h01, 8'h12, 8'h34}, 4'b0111, 1, 7'h79, 7'h79, 1'b1, 8'd2, 4'd0, 7'h09, 9'h001};
        tbl[2] = '{3, {8'h00, 8'h2A, 8'h05, 8'h34}, 4'b0111, 1, 7'h2A, 7'h79, 1'b1, 8'd3, 4'd0, 7'h02, 9'h12A};
        tbl[3] = '{3, {8'h00, 8'h00, 8'h1E, 8'h34}, 4'b0111, 1, 7'h79, 7'h79, 1'b0, 8'd4, 4'd0, 7'h0F, 9'h000};
        tbl[4] = '{3, {8'h00, 8'h11, 8'h04, 8'h36}, 4'b0000, 0, 7'h79, 7'h79, 1'b0, 8'd4, 4'd1, 7'h0F, 9'h000};
        tbl[5] = '{2, {8'h00, 8'h33, 8'h06, 8'h34}, 4'b0011, 0, 7'h79, 7'h79, 1'b0, 8'd4, 4'd1, 7'h0F, 9'h000};
        tbl[6] = '{4, {8'hAA, 8'h55, 8'h06, 8'h34}, 4'b0111, 1, 7'h79, 7'h55, 1'b0, 8'd5, 4'd2, 7'h03, 9'h055};
        tbl[7] = '{1, {8'h00, 8'h00, 8'h00, 8'h35}, 4'b0000, 0, 7'h79, 7'h55, 1'b0, 8'd5, 4'd3, 7'h03, 9'h055};
        tbl[8] = '{3, {8'h00, 8'h7F, 8'h14, 8'h34}, 4'b0111, 1, 7'h79, 7'h55, 1'b0, 8'd6, 4'd3, 7'h0A, 9'h07F};
        tbl[9] = '{3, {8'h00, 8'hFF, 8'h13, 8'h34}, 4'b0111, 1, 7'h79, 7'h55, 1'b1, 8'd7, 4'd3, 7'h09, 9'h1FF};

        repeat (5) @(negedge clk_i2c);
        chk("rst_sda", 32'(sda_bus), 32'h1);
        chk("rst_stb", 32'(reg_wr_stb), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_i2c);
        chk("rst_lvol", 32'(left_vol), 32'h79);
        chk("rst_rvol", 32'(right_vol), 32'h79);
        chk("rst_active", 32'(codec_active), 32'h0);
        chk("rst_fc", 32'(frame_count), 32'h0);
        chk("rst_nc", 32'(nack_count), 32'h0);
        chk("rst_waddr", 32'(reg_wr_addr), 32'h0);
        chk("rst_wdata", 32'(reg_wr_data), 32'h0);

        for (int v = 0; v < 10; v++) begin
            run_frame(tbl[v].b, tbl[v].n, -1, acks, sd);
            chk($sformatf("v%0d_acks", v), 32'(acks), 32'(tbl[v].acks));
            chk($sformatf("v%0d_stb", v), sd, tbl[v].stb);
            chk($sformatf("v%0d_lvol", v), 32'(left_vol), 32'(tbl[v].lv));
            chk($sformatf("v%0d_rvol", v), 32'(right_vol), 32'(tbl[v].rv));
            chk($sformatf("v%0d_active", v), 32'(codec_active), 32'(tbl[v].act));
            chk($sformatf("v%0d_fc", v), 32'(frame_count), 32'(tbl[v].fc));
            chk($sformatf("v%0d_nc", v), 32'(nack_count), 32'(tbl[v].nc));
            chk($sformatf("v%0d_waddr", v), 32'(reg_wr_addr), 32'(tbl[v].wa));
            chk($sformatf("v%0d_wdata", v), 32'(reg_wr_data), 32'(tbl[v].wd));
        end

        // Reset asserted while the responder is ACKing byte 1.
        i2c_start();
        send_byte(8'h34, 1'b0, seen);
        b[0] = 8'h04;
        for (int i = 7; i >= 0; i--) send_bit(b[0][i], 1'b0, seen);
        repeat (2) @(negedge clk_i2c);
        m_sda_low = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk_i2c);
            if (sda_bus === 1'b0) seen = 1'b1;
        end
        chk("midrst_ack_seen", 32'(seen), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_sda", 32'(sda_bus), 32'h1);
        chk("midrst_fc", 32'(frame_count), 32'h0);
        chk("midrst_nc", 32'(nack_count), 32'h0);
        chk("midrst_rvol", 32'(right_vol), 32'h79);
        chk("midrst_active", 32'(codec_active), 32'h0);
        scl = 1'b1;
        repeat (4) @(negedge clk_i2c);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_i2c);
        model_reset();

        for (int r = 0; r < 20; r++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 15));
            b[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34;
            b[1] = {a[6:0], 1'($urandom)};
            b[2] = 8'($urandom);
            b[3] = 8'($urandom);
            n = $urandom_range(1, 4);
            run_frame(b, n, -1, acks, sd);
            model_frame(b, n, ea, es);
            check_model($sformatf("rnd%0d", r), acks, ea, sd, es);
        end

`ifdef I2C_RESP_GLITCH_FILTER_EN
        b = {8'h00, 8'h3C, 8'h04, 8'h34};
        run_frame(b, 3, 1, acks, sd);
        model_frame(b, 3, ea, es);
        check_model("spike", acks, ea, sd, es);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
